// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences single host reads/writes onto the device bus
// with setup/strobe/hold timing and per-region wait states.
module bus_cycle_ctrl #(
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int WAIT_IO   = 0,
    parameter int WAIT_MEM  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_wdata_oe,
    input  logic [7:0] bus_rdata,
    output logic       bus_oe_n,
    output logic       bus_we_n,
    output logic       busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [6:0] NO_ADDR = 7'h7F;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wr_q, wr_d, mem_q, mem_d;
    logic [6:0] bus_addr_q, bus_addr_d;
    logic [7:0] bus_wdata_q, bus_wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic       bus_wdata_oe_q, bus_wdata_oe_d;
    logic       rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
    logic       bus_oe_n_q, bus_oe_n_d, bus_we_n_q, bus_we_n_d;
    logic       req_ready_q, req_ready_d, busy_q, busy_d;
    logic       hit_mem, hit_io, reject;

    assign hit_mem = (req_addr[6:4] == 3'h0) || (req_addr[6:4] == 3'h5);
    assign hit_io  = (req_addr == 7'h74) || (req_addr == 7'h6C) || (req_addr == 7'h2F);
    assign reject  = !(hit_mem || hit_io) || (req_write && req_addr == 7'h74);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        mem_d       = mem_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wdata_oe_d = bus_wdata_oe_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                wr_d        = req_write;
                mem_d       = hit_mem;
                rsp_rdata_d = 8'h00;
                rsp_err_d   = reject;
                if (reject) begin
                    state_d = DONE;
                end else begin
                    state_d        = SETUP;
                    cnt_d          = 4'(SETUP_CYC - 1);
                    bus_addr_d     = req_addr;
                    bus_wdata_d    = req_write ? req_wdata : 8'h00;
                    bus_wdata_oe_d = req_write;
                end
            end
            SETUP: begin
                state_d = (cnt_q == 4'd0) ? STROBE : SETUP;
                cnt_d   = (cnt_q == 4'd0) ? (mem_q ? 4'(WAIT_MEM) : 4'(WAIT_IO)) : cnt_q - 4'd1;
            end
            STROBE: begin
                state_d = (cnt_q == 4'd0) ? HOLD : STROBE;
                cnt_d   = (cnt_q == 4'd0) ? 4'(HOLD_CYC - 1) : cnt_q - 4'd1;
                // read data is sampled on the edge that closes the strobe
                rsp_rdata_d = (cnt_q == 4'd0 && !wr_q) ? bus_rdata : rsp_rdata_q;
            end
            HOLD: if (cnt_q == 4'd0) begin
                state_d        = DONE;
                bus_addr_d     = NO_ADDR;
                bus_wdata_oe_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                state_d   = IDLE;
                rsp_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        bus_oe_n_d  = !(state_d == STROBE && !wr_d);
        bus_we_n_d  = !(state_d == STROBE && wr_d);
        rsp_valid_d = state_d == DONE;
        req_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            wr_q           <= 1'b0;
            mem_q          <= 1'b0;
            bus_addr_q     <= NO_ADDR;
            bus_wdata_q    <= 8'h00;
            bus_wdata_oe_q <= 1'b0;
            rsp_rdata_q    <= 8'h00;
            rsp_err_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            bus_oe_n_q     <= 1'b1;
            bus_we_n_q     <= 1'b1;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            mem_q          <= mem_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_wdata_oe_q <= bus_wdata_oe_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            rsp_valid_q    <= rsp_valid_d;
            bus_oe_n_q     <= bus_oe_n_d;
            bus_we_n_q     <= bus_we_n_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wdata_oe = bus_wdata_oe_q;
    assign bus_oe_n     = bus_oe_n_q;
    assign bus_we_n     = bus_we_n_q;
    assign busy         = busy_q;
endmodule
